wave_rom_seq: RTL and testbench
===============================

Name: wave_rom_seq

Overview:
- Stimulus sequencer for the 64-point pipelined FFT bench.
- Drives the address of the combinational 64-entry sample ROM (cos/sin/delta tables), selects which table feeds the FFT real/imag inputs, and frames the stream.
- Each frame is a one-cycle START pulse followed by 64 valid samples, with a programmable sample-rate divider and inter-frame gap.
- Sits between the bench control process and the FFT input port.

Parameters:
- ADDR_W, 6, ROM address width; frame length is 2**ADDR_W samples.
- DW, 16, sample width.
- GAP_W, 8, width of the inter-frame gap count.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- GO  in  1  start request, sampled in IDLE only.
- ABORT  in  1  synchronous abort, highest priority after reset.
- NFRAMES  in  8  number of frames to issue, latched on accepted GO.
- MODE  in  2  table select, latched on accepted GO:
  - 0: RE=cos, IM=sin.
  - 1: RE=delta, IM=0.
  - 2: RE=cos, IM=0.
  - 3: RE=0, IM=sin.
- DIV  in  4  strobe divider, latched on GO; one sample every DIV+1 cycles.
- GAP  in  GAP_W  idle cycles between frames, latched on GO.
- ROM_ADDR  out  ADDR_W  registered ROM address.
- ROM_RE, ROM_IM, ROM_REF  in  DW each  combinational ROM data for ROM_ADDR.
- START  out  1  frame-start pulse to the FFT.
- DV  out  1  sample valid.
- DR, DI  out  DW each  registered real/imag sample.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.
- FRAME_CNT  out  8  frames completed in the current run.

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE. ROM_ADDR, START, DV, DR, DI, BUSY, DONE and FRAME_CNT all 0. Release mid-run resumes in IDLE; no DONE is issued.
- States: IDLE, PRIME, STREAM, GAPW, FIN.
- IDLE:
  - On GO=1 with NFRAMES>0: latch MODE/DIV/GAP/NFRAMES, clear FRAME_CNT, go to PRIME.
  - On GO=1 with NFRAMES=0: go to FIN, producing a DONE pulse with no frames.
  - GO outside IDLE is ignored.
- PRIME (1 cycle): START=1, ROM_ADDR=0, clear the divider count. Next state is STREAM.
- STREAM:
  - A strobe occurs on the first STREAM cycle and then every DIV+1 cycles.
  - On a strobe: capture table data for ROM_ADDR into DR/DI per MODE (zeros where unused). DV=1 the following cycle. ROM_ADDR increments, wrapping 63 to 0.
  - DV is 1 for exactly one cycle per sample.
  - DR/DI hold their value between samples.
- Frame end: at the strobe with ROM_ADDR=63, FRAME_CNT increments. Next state:
  - FIN if FRAME_CNT+1 = NFRAMES;
  - else GAPW if GAP>0;
  - else PRIME.
- GAPW: count GAP cycles, then go to PRIME.
- Back-to-back frames (GAP=0): START of frame n+1 coincides with the last DV of frame n.
- FIN (1 cycle): DONE=1, next state IDLE. DONE coincides with the final DV.
- BUSY=1 in PRIME, STREAM, GAPW and FIN.
- Timing with DIV=0 and START at cycle P:
  - Sample k is on ROM_ADDR at cycle P+1+k.
  - DV/DR/DI for sample k appear at cycle P+2+k.
- ABORT=1 in any non-IDLE state:
  - Next cycle: state=IDLE, START=0, DV=0, BUSY=0, no DONE.
  - ROM_ADDR, DR, DI and FRAME_CNT hold their values.
- GO and ABORT asserted together in IDLE: ABORT wins and GO is dropped.
- Changing MODE, DIV or GAP mid-run has no effect until the next accepted GO.

Test Plan:
- Reset with RSTn=0 mid-stream (ROM_ADDR=20) → all outputs 0 immediately, asynchronously; after release the block stays IDLE until GO.
- MODE=0, DIV=0, NFRAMES=1, GO at cycle 0:
  - START at cycle 1.
  - DV at cycles 3..66, 64 pulses total.
  - Sample 1: DR=16'h7369, DI=16'h2FCE.
  - Sample 32: DR=16'h8004, DI=16'h0000.
  - DONE at cycle 66, BUSY low at cycle 67.
- MODE=1, NFRAMES=1: DR=16'h7FFC for samples 1,3,5,7 and 16'h0000 for all others; DI=0 throughout.
- NFRAMES=3, GAP=0, DIV=0:
  - 192 DV pulses and 3 START pulses, with the 2nd START on the last DV of frame 1.
  - FRAME_CNT=3 at DONE.
  - ROM_ADDR wraps to 0 each frame.
- DIV=3, GAP=5, NFRAMES=2:
  - DV spacing is 4 cycles.
  - 5 idle cycles between the last strobe of frame 1 and the 2nd START.
  - Samples match the DIV=0 run.
- Abort and edge cases:
  - ABORT at the 10th DV → DV and BUSY low the next cycle, no DONE, FRAME_CNT=0.
  - A GO during BUSY is ignored.
  - GO with NFRAMES=0 → DONE one cycle later, no START, no DV.

Source files
------------

// File: rtl/wave_rom_seq.sv
// Stimulus sequencer for the 64-point FFT bench: walks the sample ROM, muxes
// the selected tables onto DR/DI and frames each burst with START/DV/DONE.
`timescale 1ns/1ps
module wave_rom_seq #(
   parameter int ADDR_W = 6,
   parameter int DW     = 16,
   parameter int GAP_W  = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              GO,
   input  logic              ABORT,
   input  logic [7:0]        NFRAMES,
   input  logic [1:0]        MODE,
   input  logic [3:0]        DIV,
   input  logic [GAP_W-1:0]  GAP,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [DW-1:0]     ROM_RE,
   input  logic [DW-1:0]     ROM_IM,
   input  logic [DW-1:0]     ROM_REF,
   output logic              START,
   output logic              DV,
   output logic [DW-1:0]     DR,
   output logic [DW-1:0]     DI,
   output logic              BUSY,
   output logic              DONE,
   output logic [7:0]        FRAME_CNT
);

   typedef enum logic [2:0] {IDLE, PRIME, STREAM, GAPW, FIN} state_t;

   state_t           state;
   logic [1:0]       mode_lat;
   logic [3:0]       div_lat;
   logic [GAP_W-1:0] gap_lat;
   logic [7:0]       nframes_lat;
   logic [3:0]       div_cnt;
   logic [GAP_W-1:0] gap_cnt;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state       <= IDLE;
         mode_lat    <= '0;
         div_lat     <= '0;
         gap_lat     <= '0;
         nframes_lat <= '0;
         div_cnt     <= '0;
         gap_cnt     <= '0;
         ROM_ADDR    <= '0;
         START       <= 1'b0;
         DV          <= 1'b0;
         DR          <= '0;
         DI          <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         FRAME_CNT   <= '0;
      end else begin
         START <= 1'b0;
         DV    <= 1'b0;
         DONE  <= 1'b0;
         if (ABORT) begin
            // Address, sample and frame count deliberately hold for post-mortem.
            state <= IDLE;
            BUSY  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (GO) begin
                     BUSY <= 1'b1;
                     if (NFRAMES != 8'd0) begin
                        mode_lat    <= MODE;
                        div_lat     <= DIV;
                        gap_lat     <= GAP;
                        nframes_lat <= NFRAMES;
                        FRAME_CNT   <= '0;
                        ROM_ADDR    <= '0;
                        START       <= 1'b1;
                        state       <= PRIME;
                     end else begin
                        DONE  <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
               PRIME: begin
                  div_cnt <= '0;
                  state   <= STREAM;
               end
               STREAM: begin
                  div_cnt <= (div_cnt == div_lat) ? 4'd0 : div_cnt + 4'd1;
                  if (div_cnt == 4'd0) begin
                     case (mode_lat)
                        2'd0: begin DR <= ROM_RE;  DI <= ROM_IM; end
                        2'd1: begin DR <= ROM_REF; DI <= '0;     end
                        2'd2: begin DR <= ROM_RE;  DI <= '0;     end
                        2'd3: begin DR <= '0;      DI <= ROM_IM; end
                     endcase
                     DV       <= 1'b1;
                     ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
                     if (ROM_ADDR == {ADDR_W{1'b1}}) begin
                        FRAME_CNT <= FRAME_CNT + 8'd1;
                        if (FRAME_CNT + 8'd1 == nframes_lat) begin
                           DONE  <= 1'b1;
                           state <= FIN;
                        end else if (gap_lat != '0) begin
                           gap_cnt <= '0;
                           state   <= GAPW;
                        end else begin
                           START <= 1'b1;
                           state <= PRIME;
                        end
                     end
                  end
               end
               GAPW: begin
                  if (gap_cnt == gap_lat - GAP_W'(1)) begin
                     START <= 1'b1;
                     state <= PRIME;
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               FIN: begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_rom_seq.sv
// Scoreboard bench for wave_rom_seq: a ROM model feeds the DUT, expected
// samples are queued at issue time and a negedge monitor pops them on DV.
`timescale 1ns/1ps
module tb_wave_rom_seq;
   localparam int AW = 6;
   localparam int DW = 16;
   localparam int GW = 8;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b1;
   logic          GO = 1'b0;
   logic          ABORT = 1'b0;
   logic [7:0]    NFRAMES = 8'd0;
   logic [1:0]    MODE = 2'd0;
   logic [3:0]    DIV = 4'd0;
   logic [GW-1:0] GAP = '0;
   logic [AW-1:0] ROM_ADDR;
   logic [DW-1:0] ROM_RE, ROM_IM, ROM_REF, DR, DI;
   logic          START, DV, BUSY, DONE;
   logic [7:0]    FRAME_CNT;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];
   int dv_log[$];
   int start_log[$];
   int done_log[$];
   int done_fc[$];

   wave_rom_seq #(.ADDR_W(AW), .DW(DW), .GAP_W(GW)) dut (
      .CLK(CLK), .RSTn(RSTn), .GO(GO), .ABORT(ABORT), .NFRAMES(NFRAMES),
      .MODE(MODE), .DIV(DIV), .GAP(GAP), .ROM_ADDR(ROM_ADDR),
      .ROM_RE(ROM_RE), .ROM_IM(ROM_IM), .ROM_REF(ROM_REF),
      .START(START), .DV(DV), .DR(DR), .DI(DI), .BUSY(BUSY), .DONE(DONE),
      .FRAME_CNT(FRAME_CNT)
   );

   // ROM model: anchor points from the plan, distinct filler elsewhere.
   function automatic logic [15:0] cos_f(input logic [5:0] a);
      if (a == 6'd1)  return 16'h7369;
      if (a == 6'd32) return 16'h8004;
      return 16'h1000 + 16'(a) * 16'h0111;
   endfunction
   function automatic logic [15:0] sin_f(input logic [5:0] a);
      if (a == 6'd1)  return 16'h2FCE;
      if (a == 6'd32) return 16'h0000;
      return 16'h2000 ^ (16'(a) * 16'h0123);
   endfunction
   function automatic logic [15:0] ref_f(input logic [5:0] a);
      return (a == 6'd1 || a == 6'd3 || a == 6'd5 || a == 6'd7) ? 16'h7FFC : 16'h0000;
   endfunction
   function automatic logic [31:0] exp_f(input logic [1:0] m, input logic [5:0] a);
      case (m)
         2'd0:    return {cos_f(a), sin_f(a)};
         2'd1:    return {ref_f(a), 16'h0000};
         2'd2:    return {cos_f(a), 16'h0000};
         default: return {16'h0000, sin_f(a)};
      endcase
   endfunction

   assign ROM_RE  = cos_f(ROM_ADDR);
   assign ROM_IM  = sin_f(ROM_ADDR);
   assign ROM_REF = ref_f(ROM_ADDR);

   initial forever #5 CLK = ~CLK;
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      if (i < 0 || i >= q.size()) return -1;
      return q[i];
   endfunction

   // Monitor: logs events and compares each DV sample against the queue head.
   initial forever begin
      @(negedge CLK);
      if (!RSTn) begin
         exp_q.delete();
      end else begin
         if (DV) begin
            dv_log.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL dv_unexpected: got DV=1 with DR=%h DI=%h, want no sample (cycle %0d)", DR, DI, cyc);
            end else begin
               check("sample", {DR, DI}, exp_q.pop_front());
            end
         end
         if (START) start_log.push_back(cyc);
         if (DONE) begin
            done_log.push_back(cyc);
            done_fc.push_back(int'(FRAME_CNT));
         end
      end
   end

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic issue(input logic [1:0] m, input logic [3:0] d, input logic [7:0] g,
                        input logic [7:0] n, input int nexp, output int gcyc);
      for (int i = 0; i < nexp; i++) exp_q.push_back(exp_f(m, 6'(i % 64)));
      step();
      MODE = m; DIV = d; GAP = g; NFRAMES = n; GO = 1'b1;
      gcyc = cyc;
      step();
      GO = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_log.size() > d0) return;
         step();
      end
      total++;
      bad++;
      $display("FAIL done_timeout: got no DONE within %0d cycles, want DONE", budget);
   endtask

   task automatic wait_dv(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (dv_log.size() >= target) return;
         step();
      end
      total++;
      bad++;
      $display("FAIL dv_timeout: got %0d DV, want %0d", dv_log.size(), target);
   endtask

   initial begin
      int g, s0, v0, d0, viol;
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, s0, v0, d0, viol;

      // Power-on reset
      #2 RSTn = 1'b0;
      #1;
      check("rst_addr", 32'(ROM_ADDR), 0);
      check("rst_ctl", {28'd0, START, DV, BUSY, DONE}, 0);
      check("rst_data", {DR, DI}, 0);
      check("rst_fcnt", 32'(FRAME_CNT), 0);
      step();
      RSTn = 1'b1;
      step();

      // Mode 0, DIV 0, one frame: exact timing
      s0 = start_log.size(); v0 = dv_log.size(); d0 = done_log.size();
      issue(2'd0, 4'd0, 8'd0, 8'd1, 64, g);
      wait_done(d0, 200);
      check("m0_starts", start_log.size() - s0, 1);
      check("m0_start_cyc", qget(start_log, s0), g + 1);
      check("m0_dv_cnt", dv_log.size() - v0, 64);
      check("m0_first_dv", qget(dv_log, v0), g + 3);
      check("m0_last_dv", qget(dv_log, v0 + 63), g + 66);
      check("m0_done_cyc", qget(done_log, d0), g + 66);
      check("m0_done_fcnt", qget(done_fc, d0), 1);
      step();
      check("m0_busy_after", {31'd0, BUSY}, 0);
      check("m0_queue_empty", exp_q.size(), 0);
      $display("run mode=0 div=0 n=1: dv=%0d start_cyc=%0d", dv_log.size() - v0, qget(start_log, s0) - g);

      // Modes 1..3, one frame each
      for (int m = 1; m < 4; m++) begin
         v0 = dv_log.size(); d0 = done_log.size();
         issue(2'(m), 4'd0, 8'd0, 8'd1, 64, g);
         wait_done(d0, 200);
         step();
         check("mode_dv_cnt", dv_log.size() - v0, 64);
         check("mode_queue_empty", exp_q.size(), 0);
         $display("run mode=%0d div=0 n=1: dv=%0d", m, dv_log.size() - v0);
      end

      // Three back-to-back frames
      s0 = start_log.size(); v0 = dv_log.size(); d0 = done_log.size();
      issue(2'd0, 4'd0, 8'd0, 8'd3, 192, g);
      wait_done(d0, 400);
      step();
      check("b2b_dv_cnt", dv_log.size() - v0, 192);
      check("b2b_starts", start_log.size() - s0, 3);
      check("b2b_start2_on_last_dv", qget(start_log, s0 + 1), qget(dv_log, v0 + 63));
      check("b2b_done_fcnt", qget(done_fc, d0), 3);
      check("b2b_done_on_last_dv", qget(done_log, d0), qget(dv_log, v0 + 191));
      $display("run mode=0 div=0 gap=0 n=3: dv=%0d starts=%0d", dv_log.size() - v0, start_log.size() - s0);

      // DIV=3, GAP=5, two frames; inputs changed mid-run must not matter
      s0 = start_log.size(); v0 = dv_log.size(); d0 = done_log.size();
      issue(2'd0, 4'd3, 8'd5, 8'd2, 128, g);
      MODE = 2'd1; DIV = 4'd0; GAP = 8'd0;
      wait_done(d0, 1000);
      step();
      viol = 0;
      for (int i = 0; i < 63; i++) begin
         if (qget(dv_log, v0 + i + 1) - qget(dv_log, v0 + i) != 4) viol++;
         if (qget(dv_log, v0 + 65 + i) - qget(dv_log, v0 + 64 + i) != 4) viol++;
      end
      check("div_dv_cnt", dv_log.size() - v0, 128);
      check("div_spacing_viol", viol, 0);
      check("gap_start2", qget(start_log, s0 + 1), qget(dv_log, v0 + 63) + 5);
      check("div_done_fcnt", qget(done_fc, d0), 2);
      check("div_queue_empty", exp_q.size(), 0);
      $display("run mode=0 div=3 gap=5 n=2: dv=%0d starts=%0d", dv_log.size() - v0, start_log.size() - s0);

      // Abort at the 10th DV, with an ignored GO during BUSY
      s0 = start_log.size(); v0 = dv_log.size(); d0 = done_log.size();
      issue(2'd0, 4'd0, 8'd0, 8'd2, 10, g);
      wait_dv(v0 + 5, 100);
      NFRAMES = 8'd0; GO = 1'b1;
      step();
      GO = 1'b0;
      wait_dv(v0 + 10, 100);
      ABORT = 1'b1;
      step();
      ABORT = 1'b0;
      check("abort_dv", {31'd0, DV}, 0);
      check("abort_busy", {31'd0, BUSY}, 0);
      check("abort_addr_hold", 32'(ROM_ADDR), 10);
      check("abort_data_hold", {DR, DI}, exp_f(2'd0, 6'd9));
      check("abort_fcnt", 32'(FRAME_CNT), 0);
      for (int i = 0; i < 6; i++) step();
      check("abort_dv_total", dv_log.size() - v0, 10);
      check("abort_no_done", done_log.size() - d0, 0);
      check("abort_starts", start_log.size() - s0, 1);
      $display("run abort: dv=%0d done=%0d", dv_log.size() - v0, done_log.size() - d0);

      // GO with NFRAMES=0
      s0 = start_log.size(); v0 = dv_log.size(); d0 = done_log.size();
      issue(2'd0, 4'd0, 8'd0, 8'd0, 0, g);
      wait_done(d0, 10);
      step();
      check("n0_done_cyc", qget(done_log, d0), g + 1);
      check("n0_no_start", start_log.size() - s0, 0);
      check("n0_no_dv", dv_log.size() - v0, 0);
      $display("run n=0: done_cyc=%0d", qget(done_log, d0) - g);

      // GO and ABORT together in IDLE
      s0 = start_log.size(); d0 = done_log.size();
      NFRAMES = 8'd1; GO = 1'b1; ABORT = 1'b1;
      step();
      GO = 1'b0; ABORT = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("goabort_busy", {31'd0, BUSY}, 0);
      check("goabort_no_start", start_log.size() - s0, 0);
      check("goabort_no_done", done_log.size() - d0, 0);
      $display("run go+abort idle: starts=%0d", start_log.size() - s0);

      // Asynchronous reset mid-stream at ROM_ADDR=20
      d0 = done_log.size();
      issue(2'd0, 4'd0, 8'd0, 8'd1, 64, g);
      for (int i = 0; i < 100 && ROM_ADDR != 6'd20; i++) step();
      check("mid_addr_reached", 32'(ROM_ADDR), 20);
      #2 RSTn = 1'b0;
      #1;
      check("mid_rst_addr", 32'(ROM_ADDR), 0);
      check("mid_rst_ctl", {28'd0, START, DV, BUSY, DONE}, 0);
      check("mid_rst_data", {DR, DI}, 0);
      check("mid_rst_fcnt", 32'(FRAME_CNT), 0);
      step();
      step();
      RSTn = 1'b1;
      s0 = start_log.size(); v0 = dv_log.size();
      for (int i = 0; i < 6; i++) step();
      check("mid_idle_busy", {31'd0, BUSY}, 0);
      check("mid_idle_dv", dv_log.size() - v0, 0);
      check("mid_idle_start", start_log.size() - s0, 0);
      check("mid_no_done", done_log.size() - d0, 0);
      $display("run reset mid-stream: busy=%0d", BUSY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
